// File: rtl/parity_mem_responder.sv
// rtl/parity_mem_responder.sv - parity-protected tagged memory responder
//
// Services single-cycle write/read commands against a tagged array of
// {valid, tag, parity, data} entries. Even parity is generated on write
// and checked on read; read results are registered (1-cycle latency).
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   write, read        command strobes, sampled on posedge
//   address            command address (idx = LSBs, tag = MSBs)
//   data_in            write data
//   inj_par_err        with write, stores inverted parity
//   data_out           {parity, data} read result
//   rd_valid           one-cycle pulse qualifying data_out/miss/par_err
//   miss               read found an invalid or tag-mismatched entry
//   par_err            stored word has odd ones count
//   busy               valid-bit clearing sweep in progress
//   err_count          saturating parity-error count
module parity_mem_responder #(
  parameter int ADDR_W = 16,
  parameter int IDX_W  = 6,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write,
  input  logic              read,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  input  logic              inj_par_err,
  output logic [DATA_W:0]   data_out,
  output logic              rd_valid,
  output logic              miss,
  output logic              par_err,
  output logic              busy,
  output logic [15:0]       err_count
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int TAG_W = ADDR_W - IDX_W;

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  logic [0:0]       state;
  logic [IDX_W-1:0] ptr;

  // Valid bits live apart from the payload arrays: they are the only part
  // of an entry that must be cleared, and the sweep does that, not reset.
  logic [DEPTH-1:0] valid_q;
  logic [TAG_W-1:0] tag_mem  [DEPTH];
  logic [DATA_W:0]  word_mem [DEPTH];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             ready;
  logic             do_wr;
  logic             do_rd;
  logic             rd_hit;
  logic [DATA_W:0]  rd_word;
  logic             rd_bad;

  assign idx     = address[IDX_W-1:0];
  assign tag     = address[ADDR_W-1:IDX_W];
  assign ready   = (state == ST_READY);
  assign do_wr   = ready & write;
  assign do_rd   = ready & read;
  assign rd_word = word_mem[idx];
  assign rd_hit  = valid_q[idx] && (tag_mem[idx] == tag);
  assign rd_bad  = rd_hit && (^rd_word);
  assign busy    = ~ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_INIT;
      ptr   <= '0;
    end else if (state == ST_INIT) begin
      ptr <= ptr + 1'b1;
      if (&ptr) begin
        state <= ST_READY;
      end
    end
  end

  // No reset here: holding rst_n low parks the sweep on entry 0, and the
  // full sweep after release clears every entry anyway.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      valid_q[ptr] <= 1'b0;
    end else if (do_wr) begin
      valid_q[idx] <= 1'b1;
    end
  end

  // Reads use the pre-edge array contents, so a same-cycle write to the
  // same entry is seen only by later reads.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      tag_mem[idx]  <= tag;
      word_mem[idx] <= {(^data_in) ^ inj_par_err, data_in};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out  <= '0;
      rd_valid  <= 1'b0;
      miss      <= 1'b0;
      par_err   <= 1'b0;
      err_count <= '0;
    end else begin
      rd_valid <= do_rd;
      miss     <= do_rd & ~rd_hit;
      par_err  <= do_rd & rd_bad;
      if (do_rd) begin
        data_out <= rd_hit ? rd_word : '0;
      end
      // Counted on the same edge that raises par_err, so err_count already
      // includes the error while rd_valid is high.
      if (do_rd && rd_bad && (err_count != 16'hFFFF)) begin
        err_count <= err_count + 16'd1;
      end
    end
  end

endmodule
